fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the main/ALU decode controller.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: instruction-memory request port plus the decode-facing instruction/PC port.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        instr_valid;
   logic        instr_ready;
   logic        pcsrc;
   logic        jump;
   logic [31:0] pc;
   logic [31:0] pcplus4;

   modport master (
      output imem_req, imem_addr, instr, op, funct, instr_valid, pc, pcplus4,
      input  imem_rdata, imem_ready, instr_ready, pcsrc, jump
   );

   modport slave (
      input  imem_req, imem_addr, instr, op, funct, instr_valid, pc, pcplus4,
      output imem_rdata, imem_ready, instr_ready, pcsrc, jump
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction, selects sequential/branch/jump next PC.
// Optional perf counters (perf_fetched, perf_stall) are built when FETCH_PERF_EN is defined.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PERF_W   = 32
) (
   input  logic clk,
   input  logic reset,
   fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_fetched,
   output logic [PERF_W-1:0] perf_stall
`endif
);

   localparam logic [0:0] S_REQ   = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;

   logic [31:0] pcplus4_c;
   logic [31:0] branch_tgt_c;
   logic [31:0] jump_tgt_c;
   logic [31:0] next_pc_c;
   logic        accept_c;
   logic        retire_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   // A response only counts once the request is actually on the bus.
   assign accept_c = (state_q == S_REQ) && req_q && bus.imem_ready;
   assign retire_c = (state_q == S_ISSUE) && bus.instr_ready;

   assign pcplus4_c    = pc_q + 32'd4;
   assign branch_tgt_c = pcplus4_c + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign jump_tgt_c   = {pcplus4_c[31:28], instr_q[25:0], 2'b00};
   assign next_pc_c    = bus.jump ? jump_tgt_c : (bus.pcsrc ? branch_tgt_c : pcplus4_c);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      req_d   = req_q;
      valid_d = valid_q;
      case (state_q)
         S_REQ: begin
            if (accept_c) begin
               instr_d = bus.imem_rdata;
               state_d = S_ISSUE;
               req_d   = 1'b0;
               valid_d = 1'b1;
            end else begin
               req_d   = 1'b1;
            end
         end
         S_ISSUE: begin
            if (retire_c) begin
               pc_d    = next_pc_c;
               state_d = S_REQ;
               req_d   = 1'b1;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.op          = instr_q[31:26];
   assign bus.funct       = instr_q[5:0];
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.pcplus4     = pcplus4_c;

`ifdef FETCH_PERF_EN
   logic [PERF_W-1:0] fetched_q;
   logic [PERF_W-1:0] stall_q;
   logic              stall_c;

   assign stall_c = ((state_q == S_REQ) && !bus.imem_ready) ||
                    ((state_q == S_ISSUE) && !bus.instr_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         fetched_q <= '0;
         stall_q   <= '0;
      end else begin
         if (retire_c) fetched_q <= fetched_q + PERF_W'(1);
         if (stall_c)  stall_q   <= stall_q + PERF_W'(1);
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model compared every cycle, plus directed address pins.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic reset;

   fetch_unit_if bus();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   fetch_unit #(.RESET_PC(32'h0000_0000), .PERF_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model: PC, held word, whether a word is held, whether a request is outstanding.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   bit          m_hold;
   bit          m_req;
   logic [31:0] m_fetched;
   logic [31:0] m_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                              input bit j, input bit b);
      longint p4;
      longint off;
      p4 = (longint'(pc) + 4) % 64'h1_0000_0000;
      if (j) return 32'((p4 / 64'h1000_0000) * 64'h1000_0000 + (longint'(ins) % 64'h400_0000) * 4);
      if (b) begin
         off = longint'(ins) % 65536;
         if (off >= 32768) off = off - 65536;
         return 32'(p4 + off * 4);
      end
      return 32'(p4);
   endfunction

   task automatic model_update();
      bit retire;
      bit stall;
      retire = m_hold && bus.instr_ready;
      stall  = (!m_hold && !bus.imem_ready) || (m_hold && !bus.instr_ready);
      if (reset) begin
         m_pc = 32'h0; m_instr = 32'h0; m_hold = 0; m_req = 0;
         m_fetched = 32'h0; m_stall = 32'h0;
      end else begin
         if (retire) m_fetched = m_fetched + 32'd1;
         if (stall)  m_stall   = m_stall + 32'd1;
         if (!m_hold) begin
            if (m_req && bus.imem_ready) begin
               m_instr = bus.imem_rdata; m_hold = 1; m_req = 0;
            end else begin
               m_req = 1;
            end
         end else if (bus.instr_ready) begin
            m_pc = model_next(m_pc, m_instr, bus.jump, bus.pcsrc);
            m_hold = 0; m_req = 1;
         end
      end
   endtask

   task automatic compare();
      chk("imem_req",    32'(bus.imem_req),    32'(m_req));
      chk("imem_addr",   bus.imem_addr,        m_pc);
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_hold));
      chk("instr",       bus.instr,            m_instr);
      chk("op",          32'(bus.op),          m_instr / 32'h0400_0000);
      chk("funct",       32'(bus.funct),       m_instr % 32'd64);
      chk("pc",          bus.pc,               m_pc);
      chk("pcplus4",     bus.pcplus4,          m_pc + 32'd4);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall",   perf_stall,   m_stall);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic idle_inputs();
      bus.imem_ready = 1'b0; bus.instr_ready = 1'b0;
      bus.pcsrc = 1'b0; bus.jump = 1'b0;
   endtask

   task automatic do_instr(input logic [31:0] w, input int ws, input bit b, input bit j, input int hold);
      int n;
      n = 0;
      idle_inputs();
      while (!bus.imem_req && n < 4) begin
         tick();
         n++;
      end
      chk("req_wait_bound", 32'(bus.imem_req), 32'd1);
      repeat (ws) tick();
      bus.imem_ready = 1'b1; bus.imem_rdata = w;
      tick();
      bus.imem_ready = 1'b0;
      repeat (hold) tick();
      bus.instr_ready = 1'b1; bus.pcsrc = b; bus.jump = j;
      tick();
      idle_inputs();
   endtask

   initial begin
      logic [31:0] seen[$];
      reset = 1'b1;
      bus.imem_rdata = 32'h0;
      idle_inputs();
      tick();
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_req",   32'(bus.imem_req),    32'd0);
      chk("rst_pc",    bus.pc,               32'h0);
      tick();
      reset = 1'b0;

      // Both readies tied high: one fetch every two cycles.
      bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; bus.imem_rdata = 32'h0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.imem_req) seen.push_back(bus.imem_addr);
      end
      chk("t1_fetch_count", 32'(seen.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < seen.size()) chk("t1_addr", seen[i], 32'(i * 4));
      bus.imem_ready = 1'b0;
      tick();
      bus.instr_ready = 1'b0;

      // Three wait states: request held four cycles, valid the cycle after ready.
      for (int k = 0; k < 4; k++) begin
         chk("t2_req_hold",  32'(bus.imem_req),    32'd1);
         chk("t2_addr_hold", bus.imem_addr,        32'h10);
         chk("t2_valid_low", 32'(bus.instr_valid), 32'd0);
         if (k == 3) bus.imem_ready = 1'b1;
         tick();
      end
      chk("t2_valid_rise", 32'(bus.instr_valid), 32'd1);
      bus.imem_ready = 1'b0; bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      chk("t2_next_addr", bus.imem_addr, 32'h14);

      // Negative branch wraps below zero, sequential wraps past the top.
      do_instr(32'h1000_FFF9, 0, 1, 0, 1);
      chk("t5_wrap_down", bus.imem_addr, 32'hFFFF_FFFC);
      do_instr(32'h0000_0000, 1, 0, 0, 0);
      chk("t5_wrap_up", bus.imem_addr, 32'h0000_0000);

      // Jump to 0x40, then backward beq taken / not taken.
      do_instr(32'h0800_0010, 0, 0, 1, 0);
      chk("t3_jump", bus.imem_addr, 32'h40);
      do_instr(32'h1000_FFFE, 2, 1, 0, 0);
      chk("t3_taken", bus.imem_addr, 32'h3C);
      do_instr(32'h0800_0010, 0, 0, 1, 2);
      do_instr(32'h1000_FFFE, 0, 0, 0, 0);
      chk("t3_not_taken", bus.imem_addr, 32'h44);

      // Walk up to 0x1000_0000 with max forward branches, then jump with pcsrc also set.
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 2048; i++) do_instr(32'h1000_7FFF, 0, 1, 0, 0);
      chk("t4_walk", bus.imem_addr, 32'h1000_0000);
      do_instr(32'h0800_0010, 0, 1, 1, 0);
      chk("t4_jump_prio", bus.imem_addr, 32'h1000_0040);

      // Reset while holding an unretired instruction.
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_ready = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("t6_pc",    bus.pc,               32'h0);
      chk("t6_valid", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
      chk("t6_perf_fetched", perf_fetched, 32'd0);
      chk("t6_perf_stall",   perf_stall,   32'd0);
`endif
      reset = 1'b0;

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         reset           = ($urandom_range(0, 255) == 0);
         bus.imem_ready  = ($urandom_range(0, 2) != 0);
         bus.imem_rdata  = $urandom();
         bus.instr_ready = ($urandom_range(0, 2) != 0);
         bus.pcsrc       = $urandom_range(0, 1) != 0;
         bus.jump        = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
